// File: rtl/gd_sample_streamer.sv
// CPU-fed stereo PCM streamer: page-5 register writes fill an L/R FIFO, rate divider pops one pair per period.
// Outputs/strobe register 1 cycle after tick; full FIFO drops pushes (sticky overflow). Option: GD_STREAM_UNDERRUN_CNT_EN.
module gd_sample_streamer #(
  parameter int          DEPTH        = 16,
  parameter logic [15:0] DEFAULT_RATE = 16'd6249
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic        mem_wr,
  input  logic [14:0] mem_w_addr,
  input  logic [7:0]  mem_data_wr,
  input  logic [14:0] mem_r_addr,
  output logic [7:0]  mem_data_rd,
  output logic [15:0] sample_l,
  output logic [15:0] sample_r,
  output logic        sample_strobe,
  output logic [4:0]  fifo_level
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]    llo_q, llo_d, lhi_q, lhi_d, rlo_q, rlo_d;
  logic [15:0]   rate_q, rate_d, cnt_q, cnt_d;
  logic          en_q, en_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]    level_q, level_d;
  logic [15:0]   sample_l_q, sample_l_d, sample_r_q, sample_r_d;
  logic          strobe_q, strobe_d;
  logic [31:0]   mem_q [DEPTH];

  logic        page_wr;
  logic [10:0] w_off;
  logic        wr_rhi, wr_ctrl, wr_status, flush;
  logic        tick, fifo_empty, pop, push_req, push_acc;

`ifdef GD_STREAM_UNDERRUN_CNT_EN
  logic [7:0] udr_cnt_q, udr_cnt_d;
`endif

  assign page_wr   = mem_wr && (mem_w_addr[14:11] == 4'd5);
  assign w_off     = mem_w_addr[10:0];
  assign wr_rhi    = page_wr && (w_off == 11'h01B);
  assign wr_ctrl   = page_wr && (w_off == 11'h01E);
  assign wr_status = page_wr && (w_off == 11'h01F);
  assign flush     = wr_ctrl && mem_data_wr[1];

  assign tick       = en_q && (cnt_q == rate_q);
  assign fifo_empty = (level_q == 5'd0);
  assign pop        = tick && !fifo_empty;
  assign push_req   = wr_rhi && !flush;
  // A full FIFO still accepts when a pop frees the head slot in the same cycle.
  assign push_acc   = push_req && ((level_q < 5'(DEPTH)) || pop);

  always_comb begin
    llo_d      = llo_q;
    lhi_d      = lhi_q;
    rlo_d      = rlo_q;
    rate_d     = rate_q;
    en_d       = en_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    sample_l_d = sample_l_q;
    sample_r_d = sample_r_q;
    strobe_d   = tick;
    cnt_d      = 16'd0;

    if (page_wr) begin
      case (w_off)
        11'h018: llo_d = mem_data_wr;
        11'h019: lhi_d = mem_data_wr;
        11'h01A: rlo_d = mem_data_wr;
        11'h01C: rate_d[7:0]  = mem_data_wr;
        11'h01D: rate_d[15:8] = mem_data_wr;
        11'h01E: en_d = mem_data_wr[0];
        default: ;
      endcase
    end

    // Counts at or past RATE wrap to 0; only equality produces a tick.
    if (en_q && (cnt_q < rate_q)) cnt_d = cnt_q + 16'd1;

    if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      sample_l_d = mem_q[rd_ptr_q][31:16];
      sample_r_d = mem_q[rd_ptr_q][15:0];
    end
    level_d = level_q + {4'd0, push_acc} - {4'd0, pop};

    if (wr_status) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (push_req && !push_acc) ovf_d = 1'b1;
    if (tick && fifo_empty)    unf_d = 1'b1;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = 5'd0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
      cnt_d      = 16'd0;
      sample_l_d = 16'd0;
      sample_r_d = 16'd0;
      strobe_d   = 1'b0;
    end
  end

`ifdef GD_STREAM_UNDERRUN_CNT_EN
  always_comb begin
    udr_cnt_d = udr_cnt_q;
    if (tick && fifo_empty && (udr_cnt_q != 8'hFF)) udr_cnt_d = udr_cnt_q + 8'd1;
    if (flush || (page_wr && (w_off == 11'h017))) udr_cnt_d = 8'd0;
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) udr_cnt_q <= 8'd0;
    else        udr_cnt_q <= udr_cnt_d;
  end
`endif

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      llo_q      <= 8'd0;
      lhi_q      <= 8'd0;
      rlo_q      <= 8'd0;
      rate_q     <= DEFAULT_RATE;
      cnt_q      <= 16'd0;
      en_q       <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= 5'd0;
      sample_l_q <= 16'd0;
      sample_r_q <= 16'd0;
      strobe_q   <= 1'b0;
    end else begin
      llo_q      <= llo_d;
      lhi_q      <= lhi_d;
      rlo_q      <= rlo_d;
      rate_q     <= rate_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      sample_l_q <= sample_l_d;
      sample_r_q <= sample_r_d;
      strobe_q   <= strobe_d;
    end
  end

  // Storage needs no reset: level and pointers define which entries are valid.
  always_ff @(posedge vga_clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= {lhi_q, llo_q, mem_data_wr, rlo_q};
  end

  always_comb begin
    mem_data_rd = 8'd0;
    if (mem_r_addr[14:11] == 4'd5) begin
      case (mem_r_addr[10:0])
`ifdef GD_STREAM_UNDERRUN_CNT_EN
        11'h017: mem_data_rd = udr_cnt_q;
`endif
        11'h01C: mem_data_rd = rate_q[7:0];
        11'h01D: mem_data_rd = rate_q[15:8];
        11'h01E: mem_data_rd = {7'd0, en_q};
        11'h01F: mem_data_rd = {unf_q, ovf_q, 1'b0, level_q};
        default: mem_data_rd = 8'd0;
      endcase
    end
  end

  assign sample_l      = sample_l_q;
  assign sample_r      = sample_r_q;
  assign sample_strobe = strobe_q;
  assign fifo_level    = level_q;

endmodule

// File: tb/tb_gd_sample_streamer.sv
// Directed bench for gd_sample_streamer: register-driven pushes, rate ticks, overflow/underrun, flush, reset.
module tb_gd_sample_streamer;

  logic        vga_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_wr = 1'b0;
  logic [14:0] mem_w_addr = 15'd0;
  logic [7:0]  mem_data_wr = 8'd0;
  logic [14:0] mem_r_addr = 15'd0;
  logic [7:0]  mem_data_rd;
  logic [15:0] sample_l, sample_r;
  logic        sample_strobe;
  logic [4:0]  fifo_level;

  int n_chk  = 0;
  int n_pass = 0;
  int lat;

  localparam logic [14:0] PG = 15'h2800;

  gd_sample_streamer dut (
    .vga_clk       (vga_clk),
    .rst_n         (rst_n),
    .mem_wr        (mem_wr),
    .mem_w_addr    (mem_w_addr),
    .mem_data_wr   (mem_data_wr),
    .mem_r_addr    (mem_r_addr),
    .mem_data_rd   (mem_data_rd),
    .sample_l      (sample_l),
    .sample_r      (sample_r),
    .sample_strobe (sample_strobe),
    .fifo_level    (fifo_level)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  task automatic wr(input logic [10:0] off, input logic [7:0] d);
    mem_w_addr  = PG | {4'd0, off};
    mem_data_wr = d;
    mem_wr      = 1'b1;
    @(posedge vga_clk);
    #1;
    mem_wr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [10:0] off, input logic [7:0] expv);
    mem_r_addr = PG | {4'd0, off};
    #1;
    chk(tag, {24'd0, mem_data_rd}, {24'd0, expv});
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    wr(11'h018, l[7:0]);
    wr(11'h019, l[15:8]);
    wr(11'h01A, r[7:0]);
    wr(11'h01B, r[15:8]);
  endtask

  initial begin
    #23 rst_n = 1'b1;
    cyc(1);

    // Reset state
    chk("rst_sample_l", sample_l, 0);
    chk("rst_sample_r", sample_r, 0);
    chk("rst_strobe", sample_strobe, 0);
    chk("rst_level", fifo_level, 0);
    rd_chk("rst_status", 11'h01F, 8'h00);
    rd_chk("rst_rate_lo", 11'h01C, 8'h69);
    rd_chk("rst_rate_hi", 11'h01D, 8'h18);
    cyc(1);
    rd_chk("rst_ctrl", 11'h01E, 8'h00);
    rd_chk("staging_reads0", 11'h018, 8'h00);
    cyc(1);

    // RATE=3, single pair, enable: 4-cycle period
    wr(11'h01C, 8'd3);
    wr(11'h01D, 8'd0);
    push(16'h1234, 16'hABCD);
    chk("level_one", fifo_level, 1);
    wr(11'h01E, 8'h01);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      cyc(1);
      if (sample_strobe) lat = i;
    end
    chk("first_tick_lat", lat, 4);
    chk("pop_l", sample_l, 16'h1234);
    chk("pop_r", sample_r, 16'hABCD);
    chk("level_zero", fifo_level, 0);
    cyc(1);
    chk("strobe_width", sample_strobe, 0);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      cyc(1);
      if (sample_strobe) lat = i;
    end
    chk("tick_interval", lat, 3);
    chk("underrun_hold_l", sample_l, 16'h1234);
    rd_chk("status_unf", 11'h01F, 8'h80);
    wr(11'h01E, 8'h00);
    wr(11'h01F, 8'h00);
    rd_chk("status_clr", 11'h01F, 8'h00);

    // Overflow: 17 pushes into 16 entries, then drain at RATE=0
    for (int i = 0; i < 17; i++) push(16'(16'h1000 + i), 16'(16'h2000 + i));
    chk("full_level", fifo_level, 16);
    rd_chk("status_ovf", 11'h01F, 8'h50);
    wr(11'h01C, 8'd0);
    wr(11'h01E, 8'h01);
    for (int k = 0; k < 16; k++) begin
      cyc(1);
      chk("drain_l", sample_l, 32'(16'(16'h1000 + k)));
      chk("drain_r", sample_r, 32'(16'(16'h2000 + k)));
    end
    chk("drained_level", fifo_level, 0);
    cyc(1);
    chk("no_17th", sample_l, 16'h100F);
    chk("empty_strobe_a", sample_strobe, 1);
    cyc(1);
    chk("empty_strobe_b", sample_strobe, 1);
    rd_chk("status_both", 11'h01F, 8'hC0);
    wr(11'h01E, 8'h00);
    wr(11'h01F, 8'h00);
    rd_chk("status_clr2", 11'h01F, 8'h00);

    // Full FIFO with push landing on a tick
    for (int i = 0; i < 16; i++) push(16'(16'h3000 + i), 16'(16'h4000 + i));
    chk("full_level2", fifo_level, 16);
    wr(11'h01C, 8'd7);
    wr(11'h01E, 8'h01);
    wr(11'h018, 8'hEF);
    wr(11'h019, 8'hBE);
    wr(11'h01A, 8'hFE);
    cyc(4);
    wr(11'h01B, 8'hCA);
    chk("full_pushpop_level", fifo_level, 16);
    rd_chk("full_pushpop_status", 11'h01F, 8'h10);
    chk("full_pushpop_l", sample_l, 16'h3000);
    chk("full_pushpop_strobe", sample_strobe, 1);
    wr(11'h01E, 8'h00);
    wr(11'h01C, 8'd0);
    wr(11'h01E, 8'h01);
    for (int k = 1; k < 16; k++) begin
      cyc(1);
      chk("drain2_l", sample_l, 32'(16'(16'h3000 + k)));
    end
    cyc(1);
    chk("last_l", sample_l, 16'hBEEF);
    chk("last_r", sample_r, 16'hCAFE);
    cyc(1);
    wr(11'h01E, 8'h00);

    // Mid-stream flush
    push(16'h6000, 16'h6100);
    push(16'h6001, 16'h6101);
    push(16'h6002, 16'h6102);
    chk("pre_flush_level", fifo_level, 3);
    wr(11'h01E, 8'h01);
    cyc(1);
    chk("pre_flush_l", sample_l, 16'h6000);
    wr(11'h01E, 8'h03);
    chk("flush_level", fifo_level, 0);
    chk("flush_l", sample_l, 0);
    chk("flush_r", sample_r, 0);
    chk("flush_strobe", sample_strobe, 0);
    rd_chk("flush_status", 11'h01F, 8'h00);
    push(16'h7777, 16'h8888);
    cyc(1);
    chk("post_flush_l", sample_l, 16'h7777);
    chk("post_flush_r", sample_r, 16'h8888);
    chk("post_flush_level", fifo_level, 0);

    // Underrun counter register
    wr(11'h01E, 8'h00);
    wr(11'h017, 8'h00);
    rd_chk("udr_cnt_clr", 11'h017, 8'h00);
    wr(11'h01E, 8'h01);
    cyc(300);
    wr(11'h01E, 8'h00);
`ifdef GD_STREAM_UNDERRUN_CNT_EN
    rd_chk("udr_cnt_sat", 11'h017, 8'hFF);
    wr(11'h017, 8'h00);
    rd_chk("udr_cnt_wrclr", 11'h017, 8'h00);
`else
    rd_chk("udr_cnt_absent", 11'h017, 8'h00);
`endif

    // Asynchronous reset mid-stream
    chk("pre_rst_l", sample_l, 16'h7777);
    rst_n = 1'b0;
    #1;
    chk("async_rst_l", sample_l, 0);
    chk("async_rst_r", sample_r, 0);
    chk("async_rst_level", fifo_level, 0);
    rd_chk("async_rst_rate", 11'h01C, 8'h69);
    rd_chk("async_rst_ctrl", 11'h01E, 8'h00);
    rst_n = 1'b1;
    cyc(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
